r5fp_mul_arb: RTL and testbench
===============================

Name: r5fp_mul_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined R5FP multiplier (exp_incr -> mul -> postproc -> exp_decr chain, fixed latency) among NREQ requesters.
- Accepts operand pairs over valid/ready and issues at most one op per cycle to the shared unit.
- Tracks in-flight ops with a tag pipeline and returns each result and status to its requester through a one-entry response buffer.
- Sits between FPU issue ports (e.g. scalar pipe, FMA helper) and the single shared multiplier instance.

Parameters:
- EXP_W, 5, exponent width of the IEEE format.
- SIG_W, 10, stored significand width; operand width W = EXP_W+SIG_W+1.
- NREQ, 2, number of requesters (2..8).
- LAT, 2, shared multiplier latency in cycles from mul_in_vld to mul_z valid (0 = combinational).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous active-high reset.
- req_vld  in  NREQ  request valid, one bit per requester.
- req_rdy  out  NREQ  request accepted this cycle (one-hot or zero).
- req_a  in  NREQ*W  operand a; requester i at [i*W +: W].
- req_b  in  NREQ*W  operand b, same packing.
- req_rnd  in  NREQ*3  rounding mode, R5FP encoding; requester i at [i*3 +: 3].
- rsp_vld  out  NREQ  result valid per requester.
- rsp_rdy  in  NREQ  result consumed.
- rsp_z  out  NREQ*W  result, same packing as req_a.
- rsp_status  out  NREQ*8  8-bit status, DW-compatible, from postproc.
- mul_in_vld  out  1  issue strobe to the shared multiplier.
- mul_a, mul_b  out  W  issued operands (registered).
- mul_rnd  out  3  issued rounding mode (registered).
- mul_z  in  W  multiplier result.
- mul_status  in  8  multiplier status.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: req_rdy=0, rsp_vld=0, rsp_z=0, rsp_status=0, mul_in_vld=0, mul_a/mul_b/mul_rnd=0, ptr=0, inflight=0, tag pipeline valid bits=0.
- Eligibility: elig[i] = req_vld[i] & ~inflight[i] & ~rsp_vld[i]. A requester therefore has at most one op outstanding.
- Grant:
  - Combinational from registered state plus req_vld.
  - Winner is the first eligible index scanning ptr, ptr+1, ... modulo NREQ.
  - req_rdy is one-hot on the winner, or 0 when no requester is eligible.
  - Inactive during reset.
- On accept of index g at cycle t:
  - mul_a/b/rnd load the operands of g.
  - inflight[g] sets.
  - ptr becomes (g+1) mod NREQ, wrapping NREQ-1 -> 0.
  - ptr is unchanged when no grant occurs.
- Issue: mul_in_vld is high in cycle t+1 only. With no accept, mul_in_vld=0 and mul_a/b/rnd hold their values.
- Tag pipeline:
  - LAT+1 stages of {valid, index}.
  - Stage 0 is loaded alongside mul_in_vld.
  - Stage LAT is aligned with mul_z.
- Capture:
  - When the stage-LAT valid bit is set with index k (cycle t+1+LAT), mul_z/mul_status are written into rsp_z/rsp_status slot k.
  - rsp_vld[k] sets and inflight[k] clears at the same edge.
  - rsp_vld[k] is high from cycle t+2+LAT.
  - Total accept-to-response latency is LAT+2.
- Response: the slot holds its data stable while rsp_vld[k]=1 and rsp_rdy[k]=0. On rsp_vld&rsp_rdy, rsp_vld clears at the edge; rsp_z/rsp_status keep stale data.
- Re-issue: requester k becomes eligible no earlier than the cycle after its response pop. There is no bypass.
- Back-to-back issue: different requesters may be accepted in consecutive cycles, giving full throughput of one op per cycle. A capture can never collide with a full slot, because issue to k is blocked while inflight[k] or rsp_vld[k] is set.
- Simultaneous events: accept for i and capture for k≠i in the same cycle are both performed. Accept for k and capture for k in the same cycle cannot happen (inflight[k] blocks the accept).
- Mid-operation reset:
  - All tag valid bits clear.
  - Results arriving on mul_z in later cycles are ignored.
  - No rsp_vld is raised for ops issued before reset.
- Data path: mul_z and mul_status pass through unmodified, including NaN payloads, so the arbiter is format-agnostic.
- Parameter check: NREQ outside 2..8 or LAT<0 triggers a $error at elaboration.

Test Plan:
- Single op, LAT=2, half precision: req 0 sends a=0x3E00 (1.5), b=0x4000 (2.0), rnd=0 at cycle 0 -> mul_in_vld at cycle 1; rsp_vld[0] at cycle 4 with rsp_z=0x4200 (3.0), status=0.
- Contention: req 0 and req 1 both valid at cycle 0 with ptr=0 -> grant 0 at cycle 0, grant 1 at cycle 1; rsp_vld[0] at cycle 4, rsp_vld[1] at cycle 5; ptr returns to 0.
- Backpressure: rsp_rdy[0]=0 for 10 cycles while req_vld[0] stays high -> req_rdy[0]=0 throughout; rsp_z[0] is stable; after pop at cycle c, the next accept is at c+1.
- Round-robin wrap with NREQ=3 and all requesters continuously valid, responses popped immediately -> grant order 0,1,2,0,1,2; each requester's next grant lags its own response.
- Reset asserted the cycle after mul_in_vld -> no rsp_vld ever rises for that op; inflight=0 and ptr=0 after reset; a fresh request is accepted the cycle reset deasserts.
- Status pass-through: mul_z=0x7E01 (NaN), mul_status=0x04 driven by the bench model -> rsp_z=0x7E01 and rsp_status=0x04 on the tagged requester only; other slots are unchanged.

Source files
------------

// File: rtl/r5fp_mul_arb.sv
`default_nettype none
//==============================================================================
// Module   : r5fp_mul_arb
// Brief    : Round-robin arbiter and sequencer sharing one pipelined R5FP
//            multiplier between NREQ requesters. Each requester may have one
//            op in flight. Its result comes back through a one-entry
//            response slot.
// Revision : 1.0 - initial release
//==============================================================================
module r5fp_mul_arb #(
  parameter int EXP_W = 5,
  parameter int SIG_W = 10,
  parameter int NREQ  = 2,
  parameter int LAT   = 2,
  localparam int W    = EXP_W + SIG_W + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_vld,
  output logic [NREQ-1:0]     req_rdy,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  input  logic [NREQ*3-1:0]   req_rnd,
  output logic [NREQ-1:0]     rsp_vld,
  input  logic [NREQ-1:0]     rsp_rdy,
  output logic [NREQ*W-1:0]   rsp_z,
  output logic [NREQ*8-1:0]   rsp_status,
  output logic                mul_in_vld,
  output logic [W-1:0]        mul_a,
  output logic [W-1:0]        mul_b,
  output logic [2:0]          mul_rnd,
  input  logic [W-1:0]        mul_z,
  input  logic [7:0]          mul_status
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW    = PTR_W + 1;

  // Illegal configurations are rejected at elaboration
  if ((NREQ < 2) || (NREQ > 8) || (LAT < 0)) begin : g_param_check
    $error("r5fp_mul_arb: NREQ must be 2..8 and LAT must be >= 0");
  end

  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [NREQ-1:0]           inflight_q, inflight_d;
  logic [NREQ-1:0]           rsp_vld_q, rsp_vld_d;
  logic [NREQ*W-1:0]         rsp_z_q, rsp_z_d;
  logic [NREQ*8-1:0]         rsp_status_q, rsp_status_d;
  logic                      mul_in_vld_q, mul_in_vld_d;
  logic [W-1:0]              mul_a_q, mul_a_d;
  logic [W-1:0]              mul_b_q, mul_b_d;
  logic [2:0]                mul_rnd_q, mul_rnd_d;
  logic [LAT:0]              tag_vld_q, tag_vld_d;
  logic [LAT:0][PTR_W-1:0]   tag_idx_q, tag_idx_d;

  logic [NREQ-1:0]           elig;
  logic                      gnt_vld;
  logic [PTR_W-1:0]          gnt_idx;
  logic [CW-1:0]             cand_sum;
  logic [PTR_W-1:0]          cand_idx;

  // Grant: first eligible requester scanning from ptr, wrapping at NREQ
  always_comb begin
    elig     = req_vld & ~inflight_q & ~rsp_vld_q;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand_sum = '0;
    cand_idx = '0;
    for (int o = 0; o < NREQ; o++) begin
      cand_sum = {1'b0, ptr_q} + CW'(o);
      if (cand_sum >= CW'(NREQ)) begin
        cand_sum = cand_sum - CW'(NREQ);
      end
      cand_idx = cand_sum[PTR_W-1:0];
      if (!gnt_vld && elig[cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    // No handshakes complete while reset is held
    if (reset) begin
      gnt_vld = 1'b0;
    end
    req_rdy = '0;
    if (gnt_vld) begin
      req_rdy[gnt_idx] = 1'b1;
    end
  end

  // Tag pipeline advances every cycle; stage 0 lines up with mul_in_vld
  if (LAT > 0) begin : g_tag_shift
    assign tag_vld_d = {tag_vld_q[LAT-1:0], gnt_vld};
    assign tag_idx_d = {tag_idx_q[LAT-1:0], gnt_idx};
  end else begin : g_tag_single
    assign tag_vld_d = gnt_vld;
    assign tag_idx_d = gnt_idx;
  end

  // Next state: issue on grant, capture when the last tag stage is valid, pop on rsp_rdy
  always_comb begin
    ptr_d        = ptr_q;
    inflight_d   = inflight_q;
    rsp_vld_d    = rsp_vld_q & ~rsp_rdy;
    rsp_z_d      = rsp_z_q;
    rsp_status_d = rsp_status_q;
    mul_in_vld_d = gnt_vld;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_rnd_d    = mul_rnd_q;

    // Capture cannot hit a full slot: the owner was blocked from issuing
    if (tag_vld_q[LAT]) begin
      rsp_vld_d[tag_idx_q[LAT]]                       = 1'b1;
      inflight_d[tag_idx_q[LAT]]                      = 1'b0;
      rsp_z_d[int'(tag_idx_q[LAT])*W +: W]            = mul_z;
      rsp_status_d[int'(tag_idx_q[LAT])*8 +: 8]       = mul_status;
    end

    // A grant never targets the slot being captured (inflight blocks it)
    if (gnt_vld) begin
      inflight_d[gnt_idx] = 1'b1;
      mul_a_d             = req_a[int'(gnt_idx)*W +: W];
      mul_b_d             = req_b[int'(gnt_idx)*W +: W];
      mul_rnd_d           = req_rnd[int'(gnt_idx)*3 +: 3];
      ptr_d               = (gnt_idx == PTR_W'(NREQ-1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  // State registers with synchronous reset; reset also flushes in-flight tags
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      inflight_q   <= '0;
      rsp_vld_q    <= '0;
      rsp_z_q      <= '0;
      rsp_status_q <= '0;
      mul_in_vld_q <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_rnd_q    <= '0;
      tag_vld_q    <= '0;
      tag_idx_q    <= '0;
    end else begin
      ptr_q        <= ptr_d;
      inflight_q   <= inflight_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_z_q      <= rsp_z_d;
      rsp_status_q <= rsp_status_d;
      mul_in_vld_q <= mul_in_vld_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_rnd_q    <= mul_rnd_d;
      tag_vld_q    <= tag_vld_d;
      tag_idx_q    <= tag_idx_d;
    end
  end

  assign rsp_vld    = rsp_vld_q;
  assign rsp_z      = rsp_z_q;
  assign rsp_status = rsp_status_q;
  assign mul_in_vld = mul_in_vld_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_rnd    = mul_rnd_q;

endmodule
`default_nettype wire

// File: tb/tb_r5fp_mul_arb.sv
`default_nettype none
//==============================================================================
// Module   : tb_r5fp_mul_arb
// Brief    : Scoreboard bench for r5fp_mul_arb (NREQ=3, LAT=2, half precision)
//            with a table-driven model of the shared multiplier.
// Revision : 1.0 - initial release
//==============================================================================
module tb_r5fp_mul_arb;

  localparam int NREQ = 3;
  localparam int LAT  = 2;
  localparam int W    = 16;
  localparam int NV   = 6;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [NREQ*W-1:0]   req_a, req_b, rsp_z;
  logic [NREQ*3-1:0]   req_rnd;
  logic [NREQ*8-1:0]   rsp_status;
  logic                mul_in_vld;
  logic [W-1:0]        mul_a, mul_b, mul_z;
  logic [2:0]          mul_rnd;
  logic [7:0]          mul_status;

  r5fp_mul_arb #(.EXP_W(5), .SIG_W(10), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b), .req_rnd(req_rnd),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_z(rsp_z), .rsp_status(rsp_status),
    .mul_in_vld(mul_in_vld), .mul_a(mul_a), .mul_b(mul_b), .mul_rnd(mul_rnd),
    .mul_z(mul_z), .mul_status(mul_status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [15:0] a; logic [15:0] b; logic [2:0] rnd; logic [15:0] z; logic [7:0] st; } vec_t;
  typedef struct packed { logic [7:0] idx; logic [7:0] v; } op_t;
  typedef struct packed { logic [7:0] idx; logic [15:0] z; logic [7:0] st; logic [31:0] cyc; } exp_t;
  typedef struct packed { logic [7:0] idx; logic [31:0] cyc; } gnt_t;

  vec_t vt [NV];
  op_t  opq [$];
  exp_t sb [$];
  gnt_t glog [$];

  logic [NREQ-1:0] acc  = '0;
  logic [NREQ-1:0] hold = '0;
  logic [NREQ-1:0] seen = '0;
  logic [15:0]     last_z [NREQ];
  logic            prev_acc = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  function automatic logic [23:0] mul_lookup(input logic [15:0] a, input logic [15:0] b, input logic [2:0] r);
    mul_lookup = {16'h5A5A, 8'hFF};
    for (int k = 0; k < NV; k++)
      if (vt[k].a == a && vt[k].b == b && vt[k].rnd == r) mul_lookup = {vt[k].z, vt[k].st};
  endfunction

  function automatic int find_op(input int i);
    find_op = -1;
    for (int j = 0; j < opq.size(); j++)
      if (int'(opq[j].idx) == i) begin find_op = j; break; end
  endfunction

  // Shared multiplier model: LAT-cycle delay line, garbage when nothing issued
  initial begin
    logic [23:0] pend;
    logic [23:0] pz [LAT];
    for (int k = 0; k < LAT; k++) pz[k] = {16'h5555, 8'hAA};
    mul_z = 16'h5555;
    mul_status = 8'hAA;
    forever begin
      @(negedge clk);
      pend = mul_in_vld ? mul_lookup(mul_a, mul_b, mul_rnd) : {16'h5555, 8'hAA};
      @(posedge clk);
      #1;
      for (int k = LAT - 1; k > 0; k--) pz[k] = pz[k-1];
      pz[0] = pend;
      {mul_z, mul_status} = pz[LAT-1];
    end
  end

  // Requester driver: presents the front op of each requester
  initial begin
    int j;
    req_vld = '0; req_a = '0; req_b = '0; req_rnd = '0; rsp_rdy = '1;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          j = find_op(i);
          if (j >= 0) opq.delete(j);
        end
      end
      acc = '0;
      for (int i = 0; i < NREQ; i++) begin
        j = find_op(i);
        req_vld[i] = (j >= 0);
        if (j >= 0) begin
          req_a[i*W +: W]   = vt[opq[j].v].a;
          req_b[i*W +: W]   = vt[opq[j].v].b;
          req_rnd[i*3 +: 3] = vt[opq[j].v].rnd;
        end
      end
      rsp_rdy = ~hold;
    end
  end

  // Monitor: logs grants, pushes expectations, pops and compares responses
  initial begin
    int j;
    exp_t e;
    gnt_t g;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_acc = 1'b0;
      end else begin
        check("mul_in_vld", mul_in_vld, prev_acc);
        check("rdy_onehot", $onehot0(req_rdy), 1);
        prev_acc = |req_rdy;
        for (int i = 0; i < NREQ; i++) begin
          if (req_rdy[i]) begin
            j = find_op(i);
            if (j < 0) begin
              fail_now("spurious_grant");
            end else begin
              acc[i] = 1'b1;
              g.idx = 8'(i); g.cyc = 32'(cyc);
              glog.push_back(g);
              e.idx = 8'(i); e.z = vt[opq[j].v].z; e.st = vt[opq[j].v].st; e.cyc = 32'(cyc + LAT + 2);
              sb.push_back(e);
            end
          end
          if (rsp_vld[i]) begin
            if (!seen[i]) begin
              j = -1;
              for (int k = 0; k < sb.size(); k++)
                if (int'(sb[k].idx) == i) begin j = k; break; end
              if (j < 0) begin
                fail_now("unexpected_rsp");
              end else begin
                check("rsp_z", rsp_z[i*W +: W], sb[j].z);
                check("rsp_status", rsp_status[i*8 +: 8], sb[j].st);
                check("rsp_cycle", 32'(cyc), sb[j].cyc);
                sb.delete(j);
              end
              seen[i]   = 1'b1;
              last_z[i] = rsp_z[i*W +: W];
            end else begin
              check("rsp_stable", rsp_z[i*W +: W], last_z[i]);
            end
            if (rsp_rdy[i]) seen[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input int i, input int v);
    op_t o;
    o.idx = 8'(i); o.v = 8'(v);
    opq.push_back(o);
  endtask

  task automatic wait_glog(input int n);
    int k;
    for (k = 0; k < 40; k++) begin
      if (glog.size() >= n) break;
      @(negedge clk);
    end
    if (k == 40) fail_now("grant_timeout");
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (opq.size() == 0 && sb.size() == 0 && rsp_vld == '0 && !reset) break;
    end
    if (k == 60) fail_now("idle_timeout");
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Directed tests
  initial begin
    int t0, c;
    vt[0] = '{a:16'h3E00, b:16'h4000, rnd:3'd0, z:16'h4200, st:8'h00}; // 1.5*2 = 3
    vt[1] = '{a:16'h4000, b:16'h4000, rnd:3'd1, z:16'h4400, st:8'h00}; // 2*2 = 4
    vt[2] = '{a:16'h3C00, b:16'h3C00, rnd:3'd2, z:16'h3C00, st:8'h00}; // 1*1 = 1
    vt[3] = '{a:16'h7E01, b:16'h3C00, rnd:3'd0, z:16'h7E01, st:8'h04}; // NaN passthrough
    vt[4] = '{a:16'h4200, b:16'h4000, rnd:3'd3, z:16'h4600, st:8'h00}; // 3*2 = 6
    vt[5] = '{a:16'h3C00, b:16'h4000, rnd:3'd4, z:16'h4000, st:8'h00}; // 1*2 = 2
    reset = 1'b1;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    check("rst_req_rdy", req_rdy, 0);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_rsp_z", rsp_z, 0);
    check("rst_rsp_status", rsp_status, 0);
    check("rst_mul_in_vld", mul_in_vld, 0);
    check("rst_mul_ops", {mul_a, mul_b, mul_rnd}, 0);
    tick();
    reset = 1'b0;

    // Single op on requester 0
    glog.delete();
    t0 = cyc;
    push_op(0, 0);
    wait_glog(1);
    if (glog.size() >= 1) begin
      check("single_idx", glog[0].idx, 0);
      check("single_cycle", glog[0].cyc, t0);
    end
    wait_idle();

    // NaN / status pass-through on requester 2, other slots untouched
    push_op(2, 3);
    wait_idle();
    check("nan_slot2_z", rsp_z[47:32], 16'h7E01);
    check("nan_slot2_st", rsp_status[23:16], 8'h04);
    check("nan_slot0_z", rsp_z[15:0], 16'h4200);
    check("nan_slot1_z", rsp_z[31:16], 16'h0000);
    check("nan_other_st", rsp_status[15:0], 16'h0000);

    // Contention between 0 and 1 with ptr at 0
    glog.delete();
    push_op(0, 1);
    push_op(1, 4);
    wait_glog(2);
    if (glog.size() >= 2) begin
      check("cont_first", glog[0].idx, 0);
      check("cont_second", glog[1].idx, 1);
      check("cont_b2b", glog[1].cyc, glog[0].cyc + 1);
    end
    wait_idle();

    // Reset the cycle after mul_in_vld: the op must vanish
    glog.delete();
    push_op(0, 0);
    wait_glog(1);
    t0 = (glog.size() >= 1) ? int'(glog[0].cyc) : cyc;
    tick();
    while (cyc < t0 + 2) tick();
    reset = 1'b1;
    sb.delete();
    seen = '0;
    glog.delete();
    push_op(0, 5);
    push_op(1, 1);
    @(negedge clk);
    check("rst_gate_rdy", req_rdy, 0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("flushed_no_rsp", rsp_vld, 0);
    end
    wait_glog(2);
    if (glog.size() >= 2) begin
      check("post_rst_idx0", glog[0].idx, 0);
      check("post_rst_cyc0", glog[0].cyc, t0 + 3);
      check("post_rst_idx1", glog[1].idx, 1);
      check("post_rst_cyc1", glog[1].cyc, t0 + 4);
    end
    wait_idle();

    // Backpressure on requester 0 with a second op waiting
    hold[0] = 1'b1;
    glog.delete();
    push_op(0, 1);
    push_op(0, 2);
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        @(negedge clk);
        if (rsp_vld[0]) break;
      end
      if (k == 20) fail_now("bp_rsp_timeout");
    end
    for (int k = 0; k < 10; k++) begin
      check("bp_req_rdy0", req_rdy[0], 0);
      check("bp_rsp_vld0", rsp_vld[0], 1);
      check("bp_rsp_z0", rsp_z[15:0], 16'h4400);
      @(negedge clk);
    end
    tick();
    hold[0] = 1'b0;
    c = cyc;
    wait_glog(2);
    if (glog.size() >= 2) begin
      check("bp_reissue_idx", glog[1].idx, 0);
      check("bp_reissue_cyc", glog[1].cyc, c + 1);
    end
    wait_idle();

    // Single op on requester 2 brings ptr back to 0
    push_op(2, 5);
    wait_idle();

    // Round-robin wrap, all three continuously valid
    glog.delete();
    push_op(0, 0); push_op(1, 1); push_op(2, 2);
    push_op(0, 4); push_op(1, 5); push_op(2, 0);
    wait_glog(6);
    if (glog.size() >= 6) begin
      for (int k = 0; k < 6; k++) check("rr_order", glog[k].idx, k % 3);
      check("rr_b2b1", glog[1].cyc, glog[0].cyc + 1);
      check("rr_b2b2", glog[2].cyc, glog[0].cyc + 2);
      for (int k = 0; k < 3; k++) check("rr_regrant", glog[k+3].cyc, glog[k].cyc + 5);
    end
    wait_idle();

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
